// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: state encoding and
// default widths/timeout used by mem_ctrl, its interface and the timeout counter.
package mem_ctrl_pkg;

  localparam int unsigned DefAddrWidth     = 9;
  localparam int unsigned DefDataWidth     = 32;
  localparam int unsigned DefTimeoutCycles = 15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of control-unit command/status and memory req/ack signals around mem_ctrl.
// master = the controller itself, slave = the surrounding control unit and memory.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) ();

  logic                  read_req;
  logic                  write_req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] Mdatain;
  logic                  mdr_read;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  timeout_err;

  modport master (
    input  read_req, write_req, addr, wdata, mem_ack, mem_rdata,
    output busy, done, Mdatain, mdr_read, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

  modport slave (
    output read_req, write_req, addr, wdata, mem_ack, mem_rdata,
    input  busy, done, Mdatain, mdr_read, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Load/count/expire counter bounding how long mem_ctrl waits for mem_ack.
// Only instantiated when MEM_CTRL_TIMEOUT_EN is defined.
module mem_timeout_cnt #(
  parameter int unsigned Cycles = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the Cycles-th enabled cycle after a load.
  assign expire_o = en_i && (cnt_q == CntW'(Cycles - 1));

endmodule

// File: rtl/mem_ctrl.sv
// MAR/MDR to main-memory access controller: one read/write per command, req/ack
// handshake, MDR load strobe on reads. MEM_CTRL_TIMEOUT_EN adds an ack timeout.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic       clock,
  input  logic       clear,
  mem_ctrl_if.master bus
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  accept;
  logic                  expire;

  assign accept = (state_q == StIdle) && (bus.read_req || bus.write_req);

`ifdef MEM_CTRL_TIMEOUT_EN
  mem_timeout_cnt #(
    .Cycles(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clock),
    .rst_i   (clear),
    .load_i  (accept),
    .en_i    (state_q == StReq),
    .expire_o(expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = !bus.read_req;  // read wins when both are requested
          tmo_d   = 1'b0;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.mem_ack) begin
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = StDone;
        end else if (expire) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.mdr_read    = (state_q == StDone) && !we_q && !tmo_q;
  assign bus.mem_req     = (state_q == StReq);
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.Mdatain     = rdata_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl: read/write handshakes, request
// priority and filtering, async clear, back-to-back timing and ack timeout.
module tb_mem_ctrl;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic clock;
  logic clear;
  int   n_checks;
  int   n_pass;
  int   done_cnt;
  int   cyc;
  int   done_cyc_last;
  int   done_cyc_prev;

  mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.done) begin
      done_cnt      <= done_cnt + 1;
      done_cyc_prev <= done_cyc_last;
      done_cyc_last <= cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command at a negedge and plays the memory with `waits` idle REQ
  // cycles before the ack; returns at the negedge of the following IDLE cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int waits,
                            input logic [DW-1:0] rdat, input logic exp_we,
                            input logic [DW-1:0] exp_mdat, input logic toggle);
    int d0;
    bus.read_req  = rd;
    bus.write_req = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    @(negedge clock);
    bus.read_req  = 1'b0;
    bus.write_req = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    d0 = done_cnt;
    check("tmo_clr_on_accept", 64'(bus.timeout_err), 64'(0));
    for (int i = 0; i < waits; i++) begin
      check("req_held", 64'(bus.mem_req), 64'(1));
      check("we_held", 64'(bus.mem_we), 64'(exp_we));
      check("addr_held", 64'(bus.mem_addr), 64'(a));
      if (exp_we) check("wdata_held", 64'(bus.mem_wdata), 64'(wd));
      check("no_early_done", 64'(bus.done), 64'(0));
      if (toggle) begin
        bus.read_req  = i[0];
        bus.write_req = !i[0];
      end
      @(negedge clock);
    end
    bus.read_req  = 1'b0;
    bus.write_req = 1'b0;
    check("req_at_ack", 64'(bus.mem_req), 64'(1));
    check("we_at_ack", 64'(bus.mem_we), 64'(exp_we));
    check("addr_at_ack", 64'(bus.mem_addr), 64'(a));
    if (exp_we) check("wdata_at_ack", 64'(bus.mem_wdata), 64'(wd));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdat;
    @(negedge clock);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    check("done_pulse", 64'(bus.done), 64'(1));
    check("mdr_read", 64'(bus.mdr_read), 64'(!exp_we));
    check("mdatain", 64'(bus.Mdatain), 64'(exp_mdat));
    check("req_dropped", 64'(bus.mem_req), 64'(0));
    check("busy_in_done", 64'(bus.busy), 64'(1));
    @(negedge clock);
    check("done_one_cycle", 64'(bus.done), 64'(0));
    check("mdr_read_one_cycle", 64'(bus.mdr_read), 64'(0));
    check("idle_not_busy", 64'(bus.busy), 64'(0));
    check("one_done", 64'(done_cnt - d0), 64'(1));
  endtask

  initial begin
    int d0;
    n_checks      = 0;
    n_pass        = 0;
    done_cnt      = 0;
    cyc           = 0;
    done_cyc_last = 0;
    done_cyc_prev = 0;
    clear         = 1'b1;
    bus.read_req  = 1'b0;
    bus.write_req = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_mem_req", 64'(bus.mem_req), 64'(0));
    check("rst_mem_we", 64'(bus.mem_we), 64'(0));
    check("rst_mdatain", 64'(bus.Mdatain), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_tmo", 64'(bus.timeout_err), 64'(0));
    clear = 1'b0;
    @(negedge clock);

    // Read with two wait cycles.
    run_access(1'b1, 1'b0, 9'h005, 32'h0, 2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    // Zero-wait write; Mdatain must keep the previous read data.
    run_access(1'b0, 1'b1, 9'h1FF, 32'h12345678, 0, 32'h0BAD0BAD, 1'b1, 32'hDEADBEEF, 1'b0);
    // Both requests high: read wins; requests toggled while busy are ignored.
    run_access(1'b1, 1'b1, 9'h022, 32'h55, 3, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b1);
    // Back-to-back zero-wait reads.
    run_access(1'b1, 1'b0, 9'h010, 32'h0, 0, 32'hAAAA0001, 1'b0, 32'hAAAA0001, 1'b0);
    run_access(1'b1, 1'b0, 9'h011, 32'h0, 0, 32'hAAAA0002, 1'b0, 32'hAAAA0002, 1'b0);
    check("b2b_done_gap", 64'(done_cyc_last - done_cyc_prev), 64'(3));

`ifdef MEM_CTRL_TIMEOUT_EN
    bus.read_req = 1'b1;
    bus.addr     = 9'h033;
    @(negedge clock);
    bus.read_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("tmo_req_held", 64'(bus.mem_req), 64'(1));
      check("tmo_no_done", 64'(bus.done), 64'(0));
      @(negedge clock);
    end
    check("tmo_done", 64'(bus.done), 64'(1));
    check("tmo_err", 64'(bus.timeout_err), 64'(1));
    check("tmo_mdr_read", 64'(bus.mdr_read), 64'(0));
    check("tmo_req_drop", 64'(bus.mem_req), 64'(0));
    check("tmo_mdatain", 64'(bus.Mdatain), 64'(32'hAAAA0002));
    @(negedge clock);
    check("tmo_idle", 64'(bus.busy), 64'(0));
    check("tmo_sticky", 64'(bus.timeout_err), 64'(1));
    run_access(1'b0, 1'b1, 9'h034, 32'h600D, 1, 32'h0, 1'b1, 32'hAAAA0002, 1'b0);
`else
    // Without the timeout the controller waits indefinitely for the ack.
    run_access(1'b1, 1'b0, 9'h033, 32'h0, 20, 32'h13572468, 1'b0, 32'h13572468, 1'b0);
    check("no_tmo_err", 64'(bus.timeout_err), 64'(0));
`endif

    // Async clear in the middle of REQ, then a stray ack.
    bus.read_req = 1'b1;
    bus.addr     = 9'h044;
    @(negedge clock);
    bus.read_req = 1'b0;
    check("clr_pre_req", 64'(bus.mem_req), 64'(1));
    #2 clear = 1'b1;
    #1;
    check("clr_mem_req", 64'(bus.mem_req), 64'(0));
    check("clr_busy", 64'(bus.busy), 64'(0));
    check("clr_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("clr_mdatain", 64'(bus.Mdatain), 64'(0));
    check("clr_mem_we", 64'(bus.mem_we), 64'(0));
    check("clr_tmo", 64'(bus.timeout_err), 64'(0));
    @(negedge clock);
    clear = 1'b0;
    d0 = done_cnt;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clock);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clock);
    check("stray_ack_no_done", 64'(done_cnt - d0), 64'(0));
    check("stray_ack_idle", 64'(bus.busy), 64'(0));
    check("stray_ack_mdatain", 64'(bus.Mdatain), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access controller between the datapath's MAR/MDR pair and the word-addressed main memory. Accepts a single read or write command from the control unit, runs a req/ack handshake with a variable-latency memory, then presents read data on `Mdatain` with a one-cycle `mdr_read` strobe. That strobe loads the MDR directly, driving its `read` and `enable` inputs. Also reports busy/done status so the control unit can stall its T-state sequence.

## Interface
- `ADDR_WIDTH`, default 9: word address width (512-word memory).
- `DATA_WIDTH`, default 32: data word width.
- `TIMEOUT_CYCLES`, default 15: maximum wait for `mem_ack` (used only with timeout feature).
- `clock`  in  1  single system clock, rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `read_req`  in  1  control unit Read command, sampled in IDLE only.
- `write_req`  in  1  control unit Write command, sampled in IDLE only.
- `addr`  in  ADDR_WIDTH  address from MAR.
- `wdata`  in  DATA_WIDTH  write data from MDR output.
- `busy`  out  1  high while a command is in progress.
- `done`  out  1  one-cycle completion pulse.
- `Mdatain`  out  DATA_WIDTH  registered read data to MDR.
- `mdr_read`  out  1  one-cycle MDR load strobe, reads only.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  ADDR_WIDTH  latched address.
- `mem_wdata`  out  DATA_WIDTH  latched write data.
- `mem_ack`  in  1  memory completion; qualified by `mem_req`.
- `mem_rdata`  in  DATA_WIDTH  read data, valid in the `mem_ack` cycle.
- `timeout_err`  out  1  sticky access-timeout flag.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: if `read_req` or `write_req` is high at the clock edge:
  - latch `addr` and `wdata`;
  - set `mem_we` (read wins if both requests are high);
  - go to REQ.
- REQ: `mem_req`=1 with address, data and `mem_we` held constant.
  - On a sampled `mem_ack`: for a read, register `mem_rdata` into `Mdatain`; go to DONE.
- DONE: `done`=1; `mdr_read`=1 if the command was a read; `mem_req`=0; next state IDLE.
- `busy`=1 in REQ and DONE; `busy`=0 in IDLE.
- Requests arriving outside IDLE are ignored. The control unit must hold or reissue them.
- `mem_ack` is ignored in IDLE and DONE.
- `Mdatain` changes only on a read ack; writes leave it untouched.
- `clear` (asynchronous, any state) forces:
  - state=IDLE;
  - `mem_req`, `mem_we`, `done`, `mdr_read`, `busy`, `timeout_err` = 0;
  - `Mdatain`, `mem_addr`, `mem_wdata` = 0.
  - Any in-flight access is abandoned. A late `mem_ack` after reset is ignored.

## Timing
- Request sampled at edge N → `mem_req` high from cycle N+1.
- `mem_ack` sampled at edge M → `done`, `mdr_read` and the new `Mdatain` valid during cycle M+1.
- IDLE (`busy`=0) in cycle M+2; the next request can be accepted at edge M+2.
- Zero-wait memory (ack in first `mem_req` cycle): `done` at N+2, 3 cycles per access.
- `mem_req` drops in the cycle after the ack (registered output); memory must not re-ack.

## Configuration
- `MEM_CTRL_TIMEOUT_EN` defined:
  - a cycle counter runs in REQ;
  - if `TIMEOUT_CYCLES` REQ cycles elapse without `mem_ack`: drop `mem_req`, go to DONE with `done`=1, `mdr_read`=0, `Mdatain` unchanged, and set `timeout_err`=1;
  - `timeout_err` clears on the next accepted request or on `clear`.
- Undefined: no counter; REQ waits indefinitely; `timeout_err` is tied to 0. The port is always present.

## Structure
- Shared package/include `mem_ctrl_pkg`: state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2), default widths, and the timeout default.
- Optional sub-module `mem_timeout_cnt`: load/count/expire counter, instantiated only under `MEM_CTRL_TIMEOUT_EN`.

## Test plan
- Read, ack after 2 wait cycles, `mem_rdata`=0xDEADBEEF, `addr`=0x05:
  - `mem_addr`=0x05 and `mem_we`=0 throughout;
  - one-cycle `done` + `mdr_read`;
  - `Mdatain`=0xDEADBEEF;
  - `busy` low afterwards.
- Write `addr`=0x1FF, `wdata`=0x12345678, zero-wait ack:
  - `mem_we`=1 with the data held;
  - `done` at N+2, `mdr_read` stays 0;
  - `Mdatain` keeps its previous value.
- `read_req` and `write_req` both high → read performed. Requests toggled while busy → ignored; exactly one `done`.
- `clear` asserted mid-REQ → all outputs reset immediately (async); a subsequent stray `mem_ack` produces no `done`.
- With `MEM_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=15, no ack:
  - `mem_req` drops after 15 cycles;
  - `done`=1, `timeout_err`=1, `mdr_read`=0;
  - the next request clears `timeout_err`.
- Back-to-back reads (0x10→0xAAAA0001, 0x11→0xAAAA0002) with zero-wait memory → two `done` pulses 3 cycles apart with correct `Mdatain` each.
